// File: rtl/gost_pkg.sv
// Shared constants for the GOST (Magma) block controller: round count, FSM encoding,
// and the key schedule index as a function of round number and direction.
package gost_pkg;

  localparam int ROUNDS = 32;
  localparam int KEY_W  = 256;
  localparam int BLK_W  = 64;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Encrypt runs K0..K7 three times then K7..K0; decrypt runs K0..K7 once then K7..K0 three times.
  function automatic logic [2:0] key_idx(input logic [4:0] rcnt, input logic encrypt);
    logic reversed;
    reversed = encrypt ? (rcnt >= 5'd24) : (rcnt >= 5'd8);
    return reversed ? (3'd7 - rcnt[2:0]) : rcnt[2:0];
  endfunction

endpackage

// File: rtl/gost_round.sv
// One Feistel round {L,R} -> {R, rotl11(S(R+K)) ^ L}; three register stages, done_o
// pulses 3 cycles after start_i. No backpressure: the caller must not restart mid-flight.
module gost_round
  import gost_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] blk_i,
  input  logic [31:0]      key_i,
  output logic             done_o,
  output logic [BLK_W-1:0] blk_o
);

  // Nibble x of box n lives at SBOX[64*n + 4*x +: 4]; box 0 handles the least significant nibble.
  localparam logic [511:0] SBOX = {
    64'h2BC96AF43850DE71, 64'h73AD0B4FC19652E8,
    64'h0E34187BAC296FD5, 64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C, 64'h069C471EDAF2853B,
    64'hF0DB74E1C5A93286, 64'h1F307D8E9B5A264C
  };

  function automatic logic [31:0] subst(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      r[4*n +: 4] = SBOX[64*n + 4*int'(a[4*n +: 4]) +: 4];
    end
    return r;
  endfunction

  logic        v1_q, v2_q, v3_q;
  logic [31:0] sum_q, l1_q, r1_q;
  logic [31:0] f_q, l2_q, r2_q;
  logic [63:0] out_q;
  logic [31:0] sub;

  assign sub = subst(sum_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      sum_q <= '0;
      l1_q  <= '0;
      r1_q  <= '0;
      f_q   <= '0;
      l2_q  <= '0;
      r2_q  <= '0;
      out_q <= '0;
    end else begin
      v1_q  <= start_i;
      sum_q <= blk_i[31:0] + key_i;
      l1_q  <= blk_i[63:32];
      r1_q  <= blk_i[31:0];
      v2_q  <= v1_q;
      f_q   <= {sub[20:0], sub[31:21]};
      l2_q  <= l1_q;
      r2_q  <= r1_q;
      v3_q  <= v2_q;
      out_q <= {r2_q, f_q ^ l2_q};
    end
  end

  assign done_o = v3_q;
  assign blk_o  = out_q;

endmodule

// File: rtl/gost_ctrl.sv
// Sequences 32 GOST rounds through one round unit: odone 129 cycles after istart acceptance,
// one block per 130 cycles; istart is only taken while oready (IDLE), otherwise ignored.
module gost_ctrl
  import gost_pkg::*;
(
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             istart,
  input  logic             iencrypt,
  input  logic [BLK_W-1:0] iblock,
  input  logic [KEY_W-1:0] ikey,
  output logic [BLK_W-1:0] oblock,
  output logic             odone,
  output logic             oready
);

  logic [1:0]       state_q, state_d;
  logic [4:0]       rcnt_q, rcnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             enc_q, enc_d;
  logic [BLK_W-1:0] oblock_q, oblock_d;

  logic             rnd_rst;
  logic             rnd_start;
  logic             rnd_done;
  logic [BLK_W-1:0] rnd_out;
  logic [2:0]       kidx;
  logic [31:0]      rnd_key;
  logic             accept;
  logic             step;

  assign kidx      = key_idx(rcnt_q, enc_q);
  assign rnd_key   = key_q[32*int'(3'd7 - kidx) +: 32];
  assign rnd_start = (state_q == ST_START);
  assign rnd_rst   = ~irst_n;
  assign accept    = (state_q == ST_IDLE) && istart;
  // A done pulse outside WAIT is not a round we launched, so it never advances state.
  assign step      = (state_q == ST_WAIT) && rnd_done;

  gost_round u_round (
    .clk_i   (iclk),
    .rst_i   (rnd_rst),
    .start_i (rnd_start),
    .blk_i   (blk_q),
    .key_i   (rnd_key),
    .done_o  (rnd_done),
    .blk_o   (rnd_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (istart) state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (rnd_done) state_d = (rcnt_q == LAST_ROUND) ? ST_DONE : ST_START;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rcnt_d   = rcnt_q;
    blk_d    = blk_q;
    key_d    = key_q;
    enc_d    = enc_q;
    oblock_d = oblock_q;
    if (accept) begin
      rcnt_d = '0;
      blk_d  = iblock;
      key_d  = ikey;
      enc_d  = iencrypt;
    end
    if (step) begin
      blk_d  = rnd_out;
      rcnt_d = rcnt_q + 5'd1;
      // The last round's output is swapped back so the result reads {L,R} like the input.
      if (rcnt_q == LAST_ROUND) oblock_d = {rnd_out[31:0], rnd_out[63:32]};
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= ST_IDLE;
      rcnt_q   <= '0;
      blk_q    <= '0;
      key_q    <= '0;
      enc_q    <= 1'b0;
      oblock_q <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      blk_q    <= blk_d;
      key_q    <= key_d;
      enc_q    <= enc_d;
      oblock_q <= oblock_d;
    end
  end

  assign oblock = oblock_q;
  assign odone  = (state_q == ST_DONE);
  assign oready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_gost_ctrl.sv
// Scoreboard bench for gost_ctrl: known Magma vectors, key-order monitor, ignored starts,
// mid-operation reset, back-to-back throughput and random encrypt/decrypt round trips.
module tb_gost_ctrl;

  localparam logic [255:0] TKEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  PT   = 64'hfedcba9876543210;
  localparam logic [63:0]  CT   = 64'h4ee901e5c2d8ca3d;

  typedef struct {
    logic [63:0] exp;
    logic        known;
    int          acc;
  } sb_t;

  logic         iclk = 1'b0;
  logic         irst_n;
  logic         istart;
  logic         iencrypt;
  logic [63:0]  iblock;
  logic [255:0] ikey;
  logic [63:0]  oblock;
  logic         odone;
  logic         oready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;

  sb_t          sb_q[$];
  int           done_cyc_q[$];
  logic [63:0]  exp_next;
  logic         known_next;
  logic [63:0]  last_out;
  logic [255:0] mon_key;
  logic         mon_enc;
  int           kmon_n;
  int           j_found;
  sb_t          e;

  gost_ctrl dut (
    .iclk     (iclk),
    .irst_n   (irst_n),
    .istart   (istart),
    .iencrypt (iencrypt),
    .iblock   (iblock),
    .ikey     (ikey),
    .oblock   (oblock),
    .odone    (odone),
    .oready   (oready)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_idx(input int r, input logic enc);
    if (enc) return (r < 24) ? (r % 8) : (31 - r);
    return (r < 8) ? r : (7 - (r % 8));
  endfunction

  // Monitor: push on acceptance, pop on odone, and track the key word fed to each round.
  always @(negedge iclk) begin
    if (irst_n) begin
      if (istart && oready) begin
        sb_q.push_back('{exp: exp_next, known: known_next, acc: cyc});
        mon_key = ikey;
        mon_enc = iencrypt;
        kmon_n  = 0;
      end
      if (dut.rnd_start && mon_key == TKEY) begin
        j_found = -1;
        for (int j = 0; j < 8; j++)
          if (mon_key[32*(7-j) +: 32] == dut.rnd_key) j_found = j;
        chk("key_idx", 64'(j_found), 64'(exp_idx(kmon_n, mon_enc)));
        kmon_n++;
      end
      if (odone) begin
        done_cyc_q.push_back(cyc);
        last_out = oblock;
        n_done++;
        if (sb_q.size() == 0) begin
          chk("spurious_odone", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'd129);
          if (e.known) chk("oblock", oblock, e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iclk);
      #2;
    end
  endtask

  task automatic start_op(input logic enc, input logic [63:0] blk, input logic [255:0] key,
                          input logic [63:0] exp, input logic known);
    exp_next   = exp;
    known_next = known;
    iencrypt   = enc;
    iblock     = blk;
    ikey       = key;
    istart     = 1'b1;
    tick(1);
    istart     = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !oready) && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [255:0] rnd_key256();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    logic [63:0]  blk, ct;
    logic [255:0] key;
    int           n0;

    irst_n = 1'b0; istart = 1'b0; iencrypt = 1'b0; iblock = '0; ikey = '0;
    exp_next = '0; known_next = 1'b0; mon_key = '0; mon_enc = 1'b0; kmon_n = 0;
    tick(3);
    chk("rst_oready", 64'(oready), 64'd1);
    chk("rst_odone", 64'(odone), 64'd0);
    chk("rst_oblock", oblock, 64'd0);
    irst_n = 1'b1;
    tick(2);
    chk("post_rst_oready", 64'(oready), 64'd1);

    // Known-answer encrypt and decrypt; oblock must then hold through IDLE.
    start_op(1'b1, PT, TKEY, CT, 1'b1);
    wait_drain(300);
    tick(20);
    chk("oblock_hold", oblock, CT);
    start_op(1'b0, CT, TKEY, PT, 1'b1);
    wait_drain(300);

    // A start pulse with different operands mid-operation must be ignored.
    start_op(1'b1, PT, TKEY, CT, 1'b1);
    tick(49);
    chk("busy_oready", 64'(oready), 64'd0);
    iblock = 64'h0123456789abcdef; ikey = rnd_key256(); iencrypt = 1'b0; istart = 1'b1;
    tick(1);
    istart = 1'b0;
    wait_drain(300);

    // Reset at cycle 60 aborts the block: no odone, oblock cleared, restart is clean.
    start_op(1'b1, PT, TKEY, CT, 1'b1);
    tick(59);
    irst_n = 1'b0;
    #1;
    chk("abort_oblock", oblock, 64'd0);
    chk("abort_oready", 64'(oready), 64'd1);
    chk("abort_odone", 64'(odone), 64'd0);
    sb_q.delete();
    tick(2);
    irst_n = 1'b1;
    n0 = n_done;
    tick(200);
    chk("abort_no_odone", 64'(n_done), 64'(n0));
    start_op(1'b1, PT, TKEY, CT, 1'b1);
    wait_drain(300);

    // istart held high: one result every 130 cycles.
    done_cyc_q.delete();
    n0 = n_done;
    exp_next = CT; known_next = 1'b1; iencrypt = 1'b1; iblock = PT; ikey = TKEY;
    istart = 1'b1;
    for (int i = 0; i < 600 && n_done < n0 + 3; i++) tick(1);
    istart = 1'b0;
    wait_drain(300);
    chk("b2b_count", 64'(done_cyc_q.size()), 64'd3);
    if (done_cyc_q.size() == 3) begin
      chk("b2b_period0", 64'(done_cyc_q[1] - done_cyc_q[0]), 64'd130);
      chk("b2b_period1", 64'(done_cyc_q[2] - done_cyc_q[1]), 64'd130);
    end

    // Random round trips: decrypt(encrypt(x)) == x.
    for (int t = 0; t < 2; t++) begin
      key = rnd_key256();
      blk = {$urandom, $urandom};
      start_op(1'b1, blk, key, '0, 1'b0);
      wait_drain(300);
      ct = last_out;
      start_op(1'b0, ct, key, blk, 1'b1);
      wait_drain(300);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
